// File: rtl/fp29i_to_fp16_if.sv
// Handshake bundle for the FP29i -> FP16 output converter.
// The slave modport is the converter's view; the master modport is the producer/consumer side.
interface fp29i_to_fp16_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sgn;
    logic [5:0]       in_exp;
    logic [21:0]      in_man_dn;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_fp16;
    logic [TAG_W-1:0] out_tag;
    logic             out_ovf;
    logic             out_unf;
    logic             out_inexact;

    modport master (
        output in_valid, in_sgn, in_exp, in_man_dn, in_tag, out_ready,
        input  in_ready, out_valid, out_fp16, out_tag, out_ovf, out_unf, out_inexact
    );

    modport slave (
        input  in_valid, in_sgn, in_exp, in_man_dn, in_tag, out_ready,
        output in_ready, out_valid, out_fp16, out_tag, out_ovf, out_unf, out_inexact
    );
endinterface

// File: rtl/fp29i_to_fp16.sv
// Converts denormalized FP29i (1/6/22, Q2.20 mantissa, bias 30) to IEEE FP16 with RNE rounding.
// Three register stages (detect, align, round/pack) under one global stall.
module fp29i_to_fp16 #(
    parameter int TAG_W      = 4,
    parameter bit SAT_ON_OVF = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    fp29i_to_fp16_if.slave bus
);

    typedef struct packed {
        logic             vld;
        logic             sgn;
        logic [5:0]       expo;
        logic [21:0]      man;
        logic [4:0]       lz_pos;
        logic             zero;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic             vld;
        logic             sgn;
        logic             zero;
        logic             tiny;
        logic [5:0]       efld;
        logic [9:0]       frac;
        logic             grd;
        logic             stk;
        logic [TAG_W-1:0] tag;
    } s2_t;

    typedef struct packed {
        logic             vld;
        logic [15:0]      fp16;
        logic [TAG_W-1:0] tag;
        logic             ovf;
        logic             unf;
        logic             inexact;
    } out_t;

    s1_t  s1_q, s1_d;
    s2_t  s2_q, s2_d;
    out_t o_q, o_d;

    logic              stall_s;
    logic signed [7:0] e16_s;
    logic              tiny_s;
    logic [21:0]       aligned_s;
    logic [5:0]        shr_s;
    logic [44:0]       src_s;
    logic [44:0]       wide_s;
    logic              rnd_s;
    logic [16:0]       sum_s;
    logic              ovf_s;
    logic              inx_s;

    function automatic logic [4:0] lead_one(input logic [21:0] m);
        logic [4:0] pos;
        pos = 5'd0;
        for (int i = 0; i < 22; i++) begin
            if (m[i]) pos = 5'(i);
        end
        return pos;
    endfunction

    assign stall_s         = o_q.vld & ~bus.out_ready;
    assign bus.in_ready    = ~stall_s;
    assign bus.out_valid   = o_q.vld;
    assign bus.out_fp16    = o_q.fp16;
    assign bus.out_tag     = o_q.tag;
    assign bus.out_ovf     = o_q.ovf;
    assign bus.out_unf     = o_q.unf;
    assign bus.out_inexact = o_q.inexact;

    // Stage 1: capture the sample and locate its leading one.
    always_comb begin
        s1_d = s1_q;
        if (!stall_s) begin
            s1_d.vld    = bus.in_valid;
            s1_d.sgn    = bus.in_sgn;
            s1_d.expo   = bus.in_exp;
            s1_d.man    = bus.in_man_dn;
            s1_d.lz_pos = lead_one(bus.in_man_dn);
            s1_d.zero   = (bus.in_man_dn == 22'd0);
            s1_d.tag    = bus.in_tag;
        end else begin
            s1_d = s1_q;
        end
    end

    // Stage 2: FP16 exponent, alignment and fraction/guard/sticky extraction.
    always_comb begin
        e16_s     = $signed({2'b00, s1_q.expo}) + $signed({3'b000, s1_q.lz_pos}) - 8'sd35;
        tiny_s    = (e16_s < 8'sd1);
        aligned_s = s1_q.man << (5'd21 - s1_q.lz_pos);
        // Subnormals keep the leading one and shift right by 1-E16; normals drop it.
        shr_s     = tiny_s ? 6'(-e16_s) : 6'd0;
        src_s     = tiny_s ? {aligned_s, 23'd0} : {aligned_s[20:0], 24'd0};
        wide_s    = src_s >> shr_s;
        s2_d      = s2_q;
        if (!stall_s) begin
            s2_d.vld  = s1_q.vld;
            s2_d.sgn  = s1_q.sgn;
            s2_d.zero = s1_q.zero;
            s2_d.tiny = tiny_s;
            s2_d.efld = tiny_s ? 6'd0 : e16_s[5:0];
            s2_d.frac = wide_s[44:35];
            s2_d.grd  = wide_s[34];
            s2_d.stk  = |wide_s[33:0];
            s2_d.tag  = s1_q.tag;
        end else begin
            s2_d = s2_q;
        end
    end

    // Stage 3: round to nearest even, detect overflow and pack the result.
    always_comb begin
        rnd_s = s2_q.grd & (s2_q.stk | s2_q.frac[0]);
        // Fraction carry ripples into the exponent field, which also lifts 0x3FF subnormals to 0x400.
        sum_s = {1'b0, s2_q.efld, s2_q.frac} + {16'd0, rnd_s};
        ovf_s = (sum_s[16:10] >= 7'd31);
        inx_s = s2_q.grd | s2_q.stk;
        o_d   = o_q;
        if (!stall_s) begin
            o_d.vld = s2_q.vld;
            o_d.tag = s2_q.tag;
            if (s2_q.zero) begin
                o_d.fp16    = {s2_q.sgn, 15'd0};
                o_d.ovf     = 1'b0;
                o_d.unf     = 1'b0;
                o_d.inexact = 1'b0;
            end else if (ovf_s) begin
                o_d.fp16    = SAT_ON_OVF ? {s2_q.sgn, 15'h7BFF} : {s2_q.sgn, 15'h7C00};
                o_d.ovf     = 1'b1;
                o_d.unf     = 1'b0;
                o_d.inexact = 1'b1;
            end else begin
                o_d.fp16    = {s2_q.sgn, sum_s[14:0]};
                o_d.ovf     = 1'b0;
                o_d.unf     = s2_q.tiny & inx_s;
                o_d.inexact = inx_s;
            end
        end else begin
            o_d = o_q;
        end
    end

    // Pipeline registers; synchronous reset flushes every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            o_q  <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            o_q  <= o_d;
        end
    end

endmodule

// File: doc/fp29i_to_fp16.md
Name: fp29i_to_fp16

Overview:
- Output-side format converter for the FIR FP datapath.
- Accepts unified FP29i results (1 sign / 6 exp / 22 mantissa, denormalized) from the FP ALU accumulate path.
- Normalizes, rounds to nearest even and packs each result into IEEE FP16 (1/5/10).
- 3-stage pipeline with valid/ready handshake; sits between the ALU output and the FIR sample output port.

Parameters:
- TAG_W, 4, width of the sideband tag carried alongside each sample unchanged.
- SAT_ON_OVF, 0, overflow policy: 0 gives ±Inf (0x7C00/0xFC00); 1 gives ±max finite (0x7BFF/0xFBFF).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  converter accepts input this cycle
- in_sgn  in  1  FP29i sign
- in_exp  in  6  FP29i exponent, bias 30
- in_man_dn  in  22  FP29i mantissa, unsigned Q2.20, denormalized
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts output
- out_fp16  out  16  packed IEEE FP16 result
- out_tag  out  TAG_W  tag of this sample
- out_ovf  out  1  result overflowed (Inf or saturated)
- out_unf  out  1  result tiny (E16<=0 before rounding) and inexact
- out_inexact  out  1  rounding discarded nonzero bits

Behaviour:
- Input value = (-1)^sgn * man * 2^-20 * 2^(exp-30). man==0 is zero regardless of exp.
- Transfer rule: a transfer occurs when valid&&ready on either side. Define stall = out_valid & ~out_ready. in_ready = ~stall.
- Stall: all three stages hold while stall=1 (global stall, no bubbles collapsed). Pipeline holds up to 3 samples.
- Latency: exactly 3 cycles from input accept to out_valid, absent stall. Throughput 1/cycle.
- Stage S1: register inputs; leading-one detect p (21..0) on man; zero flag z = (man==0).
- Stage S2: E16 = exp + p - 35 (signed, 8-bit range -35..49).
  - Normal case (E16>=1): left-align the leading one.
  - Subnormal case (E16<=0): right-shift by 1-E16; shifts >=24 collapse to sticky only.
  - Extract 10-bit fraction f, guard g and sticky s (OR of all lower bits).
- Stage S3 rounding: round up iff g & (s | f[0]).
  - Fraction carry increments the exponent.
  - Subnormal rounding up to 0x400 becomes min normal 0x0400.
- Stage S3 overflow and pack:
  - E16>=31 after rounding: overflow result per SAT_ON_OVF, out_ovf=1, out_inexact=1.
  - Zero input: out_fp16 = {sgn,15'b0}, all flags 0 (signed zero preserved).
  - out_inexact = g|s. out_unf = (E16<=0 pre-round) & inexact.
- Tag is delayed identically to the data.
- Reset values: out_valid=0, out_fp16=0, out_tag=0, all flags 0; all stage valid bits cleared.
- Reset mid-operation: in-flight samples are discarded, nothing is emitted.
- Output stability: outputs stay stable while out_valid & ~out_ready.
- Input X-safety: in_* is don't-care when in_valid=0; stage valid bits are the only qualifiers.

Test Plan:
- Exact normals: man=0x100000 exp=30 sgn=0 -> 0x3C00, flags 0. Then man=0x240000 exp=30 -> 0x4080. Both emerge 3 cycles after accept.
- RNE ties (exp=30):
  - man=0x100200 -> 0x3C00, inexact=1 (tie to even).
  - man=0x100600 -> 0x3C02.
  - man=0x1FFE00 -> 0x4000 (carry into exponent).
- Extremes:
  - man=0x200000 exp=63 sgn=1 -> 0xFC00, ovf=1; with SAT_ON_OVF=1 -> 0xFBFF.
  - man=0 exp=17 sgn=1 -> 0x8000.
  - man=0x100000 exp=15 -> 0x0200, unf=0.
  - man=0x000001 exp=0 -> 0x0000, unf=1, inexact=1.
- Backpressure: stream 6 samples back-to-back with out_ready held 0 for cycles 4-7.
  - in_ready deasserts while out_valid & ~out_ready.
  - No sample is lost or duplicated; output order and tags match input.
  - Output stays stable during the stall.
- Reset mid-stream: assert rst for 1 cycle with 3 samples in flight -> out_valid=0 next cycle, none of those samples appear, next accepted sample emerges 3 cycles later.
- Random: 10k random FP29i inputs with random ready -> bit-exact match against a reference model (exact rational value rounded RNE to FP16), including flags.
